tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_pkg.sv | 12 +
 rtl/tdm_demux4_slot.sv | 29 ++
 rtl/tdm_demux4.sv | 101 ++++++++++
 tb/tb_tdm_demux4.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared types and default sizing for the TDM_DEMUX4 time-division demultiplexer.
package tdm_demux4_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int DEFAULT_W = 8;
   localparam int DEFAULT_N = 4;

endpackage

// File: rtl/tdm_demux4_slot.sv
// One output channel: a holding register plus its valid flag with same-cycle drain/refill.
module tdm_demux4_slot
   import tdm_demux4_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         drain,
   output logic [W-1:0] data,
   output logic         valid
);

   // A load wins over a drain so a simultaneous take-and-refill keeps the channel full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Demultiplexes a framed TDM sample stream onto N channel outputs with frame-lock tracking.
// Optional feature: define TDM_DEMUX4_ERRCNT_EN to add a saturating err_cnt output.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int W = DEFAULT_W,
   parameter int N = DEFAULT_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   in_data,
   input  logic           in_valid,
   input  logic           in_sync,
   output logic           in_ready,
   output logic [N*W-1:0] ch_data,
   output logic [N-1:0]   ch_valid,
   input  logic [N-1:0]   ch_ready,
   output logic           sync_err
`ifdef TDM_DEMUX4_ERRCNT_EN
   ,
   output logic [7:0]     err_cnt
`endif
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   state_t        state;
   logic [SW-1:0] slot;
   logic [SW-1:0] target;
   logic          is_load;
   logic          accept;
   logic [N-1:0]  loads;

   // A sample is stored whenever it carries sync or we are locked mid-frame; anything else is dropped.
   always_comb begin
      target   = in_sync ? '0 : slot;
      is_load  = in_sync || ((state == LOCK) && (slot != '0));
      in_ready = is_load ? (~ch_valid[target] | ch_ready[target]) : 1'b1;
      accept   = in_valid & in_ready;
   end

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign loads[k] = accept & is_load & (target == SW'(k));

      tdm_demux4_slot #(
         .W(W)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (loads[k]),
         .load_data(in_data),
         .drain    (ch_ready[k]),
         .data     (ch_data[k*W +: W]),
         .valid    (ch_valid[k])
      );
   end

   // Frame tracker: sync always restarts the frame at slot 1, a missing sync at slot 0 drops lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         slot     <= '0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         if (accept) begin
            case (state)
               HUNT: begin
                  if (in_sync) begin
                     state <= LOCK;
                     slot  <= SW'(1);
                  end
               end
               LOCK: begin
                  if (in_sync) begin
                     sync_err <= (slot != '0);
                     slot     <= SW'(1);
                  end else if (slot == '0) begin
                     sync_err <= 1'b1;
                     state    <= HUNT;
                  end else begin
                     slot <= (slot == SW'(N - 1)) ? '0 : slot + SW'(1);
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

`ifdef TDM_DEMUX4_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (sync_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized scoreboard bench for tdm_demux4; honours TDM_DEMUX4_ERRCNT_EN when defined.
module tb_tdm_demux4;

   localparam int W = 8;
   localparam int N = 4;
   localparam logic [N-1:0] ALL = '1;

   logic           clk;
   logic           rst_n;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_sync;
   logic           in_ready;
   logic [N*W-1:0] ch_data;
   logic [N-1:0]   ch_valid;
   logic [N-1:0]   ch_ready;
   logic           sync_err;
`ifdef TDM_DEMUX4_ERRCNT_EN
   logic [7:0]     err_cnt;
   int             cnt_model = 0;
`endif

   tdm_demux4 #(.W(W), .N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_sync (in_sync),
      .in_ready(in_ready),
      .ch_data (ch_data),
      .ch_valid(ch_valid),
      .ch_ready(ch_ready),
      .sync_err(sync_err)
`ifdef TDM_DEMUX4_ERRCNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Frame model: lock flag, next slot number, per-channel occupancy and expected delivery queues.
   bit             locked = 0;
   int             slot_m = 0;
   logic [N-1:0]   occ = '0;
   logic           exp_err = 1'b0;
   logic [W-1:0]   expq [N][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] d,
                                input logic [N-1:0] r);
      int  tgt;
      bit  stores;
      bit  rdy;
      bit  nerr;
      @(posedge clk);
      #1;
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      ch_ready = r;
      @(negedge clk);
      checkOutput("sync_err", 64'(sync_err), 64'(exp_err));
`ifdef TDM_DEMUX4_ERRCNT_EN
      checkOutput("err_cnt", 64'(err_cnt), 64'(cnt_model));
      if (exp_err && cnt_model < 255) cnt_model++;
`endif
      checkOutput("ch_valid", 64'(ch_valid), 64'(occ));
      tgt    = s ? 0 : slot_m;
      stores = s || (locked && slot_m != 0);
      rdy    = stores ? (!occ[tgt] || r[tgt]) : 1'b1;
      checkOutput("in_ready", 64'(in_ready), 64'(rdy));
      nerr = 0;
      for (int k = 0; k < N; k++) if (occ[k] && r[k]) occ[k] = 1'b0;
      if (v && rdy) begin
         if (stores) begin
            expq[tgt].push_back(d);
            occ[tgt] = 1'b1;
         end
         if (s) begin
            nerr   = locked && slot_m != 0;
            locked = 1;
            slot_m = 1;
         end else if (locked && slot_m == 0) begin
            nerr   = 1;
            locked = 0;
         end else if (locked) begin
            slot_m = (slot_m + 1) % N;
         end
      end
      exp_err = nerr;
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("reset ch_valid", 64'(ch_valid), 64'(0));
      checkOutput("reset ch_data", 64'(ch_data), 64'(0));
      checkOutput("reset sync_err", 64'(sync_err), 64'(0));
      locked  = 0;
      slot_m  = 0;
      occ     = '0;
      exp_err = 1'b0;
      for (int k = 0; k < N; k++) expq[k].delete();
`ifdef TDM_DEMUX4_ERRCNT_EN
      cnt_model = 0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every delivery handshake must return the oldest sample routed to that channel.
   initial begin
      logic [W-1:0] want;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int k = 0; k < N; k++) begin
               if (ch_valid[k] && ch_ready[k]) begin
                  if (expq[k].size() == 0) begin
                     checkOutput($sformatf("ch%0d unexpected delivery", k), 64'(1), 64'(0));
                  end else begin
                     want = expq[k].pop_front();
                     checkOutput($sformatf("ch%0d data", k), 64'(ch_data[k*W +: W]), 64'(want));
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = '0;
      ch_ready = '0;
      #1;
      checkOutput("por ch_valid", 64'(ch_valid), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Nominal frame A0..A3 with every consumer ready.
      applyStimulus(1, 1, 8'hA0, ALL);
      applyStimulus(1, 0, 8'hA1, ALL);
      applyStimulus(1, 0, 8'hA2, ALL);
      applyStimulus(1, 0, 8'hA3, ALL);
      applyStimulus(0, 0, 8'h00, ALL);
      applyStimulus(0, 0, 8'h00, ALL);

      // Hunting: unsynced samples are dropped until a sync arrives.
      applyReset();
      applyStimulus(1, 0, 8'h11, ALL);
      applyStimulus(1, 0, 8'h22, ALL);
      applyStimulus(1, 1, 8'h33, ALL);
      applyStimulus(0, 0, 8'h00, ALL);

      // Backpressure on channel 1, then release with same-cycle drain and refill.
      applyStimulus(1, 0, 8'h41, 4'b1101);
      applyStimulus(1, 0, 8'h42, 4'b1101);
      applyStimulus(1, 0, 8'h43, 4'b1101);
      applyStimulus(1, 1, 8'h44, 4'b1101);
      applyStimulus(1, 0, 8'h45, 4'b1101);
      applyStimulus(1, 0, 8'h45, 4'b1111);
      applyStimulus(0, 0, 8'h00, 4'b1101);
      applyStimulus(0, 0, 8'h00, ALL);

      // Misplaced sync at slot 2, then a missing sync at slot 0.
      applyStimulus(1, 1, 8'h50, ALL);
      applyStimulus(1, 0, 8'h51, ALL);
      applyStimulus(1, 1, 8'h52, ALL);
      applyStimulus(1, 0, 8'h53, ALL);
      applyStimulus(1, 0, 8'h54, ALL);
      applyStimulus(1, 0, 8'h55, ALL);
      applyStimulus(1, 0, 8'h56, ALL);
      applyStimulus(1, 0, 8'h57, ALL);
      applyStimulus(0, 0, 8'h00, ALL);

      // Reset mid-frame with channels 0 and 1 still holding samples.
      applyStimulus(1, 1, 8'h60, '0);
      applyStimulus(1, 0, 8'h61, '0);
      applyStimulus(0, 0, 8'h00, '0);
      checkOutput("pre-reset ch_valid", 64'(ch_valid), 64'(4'b0011));
      applyReset();
      applyStimulus(1, 0, 8'h62, ALL);
      applyStimulus(0, 0, 8'h00, ALL);

`ifdef TDM_DEMUX4_ERRCNT_EN
      applyStimulus(1, 1, 8'h70, ALL);
      for (int i = 0; i < 300; i++) applyStimulus(1, 1, 8'(i), ALL);
      applyStimulus(0, 0, 8'h00, ALL);
      applyStimulus(0, 0, 8'h00, ALL);
      checkOutput("err_cnt saturated", 64'(err_cnt), 64'(255));
`endif

      // Random traffic biased toward well-formed frames.
      for (int i = 0; i < 3000; i++) begin
         logic v, s;
         if ($urandom_range(0, 299) == 0) applyReset();
         v = ($urandom_range(0, 3) != 0);
         if (locked && slot_m == 0) s = ($urandom_range(0, 9) != 0);
         else s = ($urandom_range(0, 11) == 0);
         applyStimulus(v, s, W'($urandom), N'($urandom_range(0, 15) | $urandom_range(0, 15)));
      end
      applyStimulus(0, 0, 8'h00, ALL);
      applyStimulus(0, 0, 8'h00, ALL);
      @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
